wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Shares the single register-file write port between the pipeline writeback stage (MEM/WB outputs after the MemToReg mux) and the multi-cycle multiply/divide unit. Multiply/divide results are buffered in a small pending FIFO and drained into cycles where writeback does not use the port. A starvation counter forces a one-cycle pipeline stall when the FIFO cannot drain. Register hazards against pending results are reported to the decode stage.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 2, pending FIFO entries (power of two)
- STARVE_MAX, 4, consecutive denied cycles before a forced drain
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- wb_RegWrite  in  1  writeback stage requests a write
- wb_reg_dest  in  ADDR_W  writeback destination
- wb_data  in  DATA_W  writeback data
- md_valid  in  1  mul/div result offered
- md_ready  out  1  FIFO can accept (= not full)
- md_reg_dest  in  ADDR_W  mul/div destination
- md_data  in  DATA_W  mul/div result
- rf_we, rf_waddr, rf_wdata  out  1/ADDR_W/DATA_W  registered write port to the register file
- stall_req  out  1  freeze IF..WB for one cycle
- rs_addr, rt_addr  in  ADDR_W  decode source registers
- hazard_rs, hazard_rt  out  1  source matches a valid non-stale pending entry

## Operation
- Push: md_valid && md_ready. Accepted with md_reg_dest==0 → discarded, not stored. No bypass: a pushed entry is grantable from the next cycle.
- Entry = {dest, data, stale}. A granted WB write whose dest equals a valid entry's dest sets that entry's stale bit, so a newer WB value is never overwritten by an older mul/div result.
- Grant per cycle, in priority order:
  1. stall_req==1: grant the FIFO head; WB inputs are ignored, because the pipeline holds them.
  2. wb_RegWrite && wb_reg_dest!=0: grant WB. If the head is stale, pop it in the same cycle with no write.
  3. Otherwise, the head is popped if one exists. It is written only if non-stale.
- WB writes with wb_reg_dest==0 are dropped and leave the port free.
- Age counter:
  - Increments each cycle the head is valid, non-stale, and not popped.
  - Clears on pop or when the FIFO is empty.
  - When age reaches STARVE_MAX-1 on an increment, stall_req is registered high for the next cycle.
- stall_req is high for exactly one cycle per event and is never high while the FIFO is empty.
- hazard_rs/rt are combinational over the stored entries:
  - Addr!=0 and matches a valid non-stale entry.
  - An entry being popped this cycle still counts.
  - A push in the same cycle does not count yet.
- Reset (async assert, sync deassert behaviour at the next edge):
  - FIFO empty, age=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0.
  - md_ready=1, hazard_rs=hazard_rt=0.
  - Reset mid-drain discards all pending entries.

## Timing
- rf_* outputs are registered. A grant decided in cycle N drives rf_* during cycle N+1, with rf_we=1 for one cycle per write.
- md_ready depends only on occupancy, with no combinational path from md_valid. When full, md_ready=0 even if a pop occurs the same cycle.
- Forced-drain latency: head pushed at cycle P, WB busy every cycle → stall_req high in cycle P+STARVE_MAX, rf_we for the head in P+STARVE_MAX+1.
- A pop and a push in the same cycle keep occupancy unchanged. Pointers wrap modulo DEPTH.

## Structure
- Package wb_arb_pkg holds:
  - DATA_W, ADDR_W, DEPTH, STARVE_MAX defaults.
  - typedef pend_entry_t {dest, data, stale}.
  - typedef grant_t {GNT_NONE, GNT_WB, GNT_PEND}.
- Sub-module wb_pend_fifo contains:
  - The DEPTH-entry FIFO with valid/stale bits.
  - The dest-compare logic for stale marking.
  - The two hazard lookup ports.
- The top level contains the grant logic, the age counter, stall_req, and the rf_* output register.

## Test plan
- **Idle WB:** md push {dest=3, data=0x11}, wb_RegWrite=0 → rf_we=1, waddr=3, wdata=0x11 two cycles after the push cycle; hazard_rt high for rt=3 only in the cycle after push.
- **Collision:** md push dest=4 and continuous WB writes to dest=7 → 4 denied cycles, stall_req pulses once, then rf write to 4 (0x22) with no WB write that cycle; WB write to 7 resumes next cycle.
- **Stale:** push dest=5 (0xAA) then WB writes 5 (0xBB) → only 0xBB written to r5; entry popped silently; hazard_rs for rs=5 drops.
- **Full:** two pushes with WB busy → md_ready=0; third md_valid held until a pop; all three written in push order.
- **Zero register:** md dest=0 and WB dest=0 → no rf_we, FIFO stays empty, no stall.
- **Reset mid-operation:** assert reset_n=0 with 2 pending entries → all outputs at reset values immediately; no subsequent writes of those entries.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
// Imported by the pending FIFO, the bus interface and the top level.
package wb_arb_pkg;

    localparam int unsigned WB_DATA_W     = 32;
    localparam int unsigned WB_ADDR_W     = 5;
    localparam int unsigned WB_DEPTH      = 2;
    localparam int unsigned WB_STARVE_MAX = 4;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] dest;
        logic [WB_DATA_W-1:0] data;
        logic                 stale;
    } pend_entry_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_PEND
    } grant_t;

    // True when a non-zero source register names the given destination.
    function automatic logic addr_hit(
        input logic [WB_ADDR_W-1:0] src,
        input logic [WB_ADDR_W-1:0] dst
    );
        return (src != '0) && (src == dst);
    endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between writeback, mul/div, decode and the register file.
// slave = arbiter side, master = surrounding pipeline side.
interface wb_write_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
);

    logic              wb_RegWrite;
    logic [ADDR_W-1:0] wb_reg_dest;
    logic [DATA_W-1:0] wb_data;

    logic              md_valid;
    logic              md_ready;
    logic [ADDR_W-1:0] md_reg_dest;
    logic [DATA_W-1:0] md_data;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    logic              stall_req;

    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              hazard_rs;
    logic              hazard_rt;

    modport slave (
        input  wb_RegWrite, wb_reg_dest, wb_data,
        input  md_valid, md_reg_dest, md_data,
        input  rs_addr, rt_addr,
        output md_ready,
        output rf_we, rf_waddr, rf_wdata,
        output stall_req,
        output hazard_rs, hazard_rt
    );

    modport master (
        output wb_RegWrite, wb_reg_dest, wb_data,
        output md_valid, md_reg_dest, md_data,
        output rs_addr, rt_addr,
        input  md_ready,
        input  rf_we, rf_waddr, rf_wdata,
        input  stall_req,
        input  hazard_rs, hazard_rt
    );

endinterface

// File: rtl/wb_pend_fifo.sv
// Pending mul/div result FIFO with per-entry valid/stale bits,
// stale marking on newer WB writes, and two decode hazard lookups.
module wb_pend_fifo
    import wb_arb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 i_push,
    input  logic [WB_ADDR_W-1:0] i_push_dest,
    input  logic [WB_DATA_W-1:0] i_push_data,
    input  logic                 i_pop,
    input  logic                 i_mark,
    input  logic [WB_ADDR_W-1:0] i_mark_dest,
    input  logic [WB_ADDR_W-1:0] i_rs_addr,
    input  logic [WB_ADDR_W-1:0] i_rt_addr,
    output logic                 o_full,
    output logic                 o_head_valid,
    output pend_entry_t          o_head,
    output logic                 o_hazard_rs,
    output logic                 o_hazard_rt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    pend_entry_t      r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;

    logic w_haz_rs;
    logic w_haz_rt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage: mark stale on matching WB writes, then pop, then push.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i_mark && r_valid[i] && (r_mem[i].dest == i_mark_dest)) begin
                    r_mem[i].stale <= 1'b1;
                end
            end
            if (i_pop) begin
                r_valid[r_rptr] <= 1'b0;
                r_rptr          <= ptr_inc(r_rptr);
            end
            if (i_push) begin
                r_mem[r_wptr]   <= '{dest: i_push_dest, data: i_push_data, stale: 1'b0};
                r_valid[r_wptr] <= 1'b1;
                r_wptr          <= ptr_inc(r_wptr);
            end
        end
    end

    // Hazard lookup over stored entries; same-cycle pushes are not visible.
    always_comb begin
        w_haz_rs = 1'b0;
        w_haz_rt = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_valid[i] && !r_mem[i].stale) begin
                if (addr_hit(i_rs_addr, r_mem[i].dest)) w_haz_rs = 1'b1;
                if (addr_hit(i_rt_addr, r_mem[i].dest)) w_haz_rt = 1'b1;
            end
        end
    end

    assign o_full       = &r_valid;
    assign o_head_valid = r_valid[r_rptr];
    assign o_head       = r_mem[r_rptr];
    assign o_hazard_rs  = w_haz_rs;
    assign o_hazard_rt  = w_haz_rt;

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter between writeback and mul/div results.
// Grants, age/starvation tracking, stall request and registered rf port.
module wb_write_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned DATA_W     = WB_DATA_W,
    parameter int unsigned ADDR_W     = WB_ADDR_W,
    parameter int unsigned DEPTH      = WB_DEPTH,
    parameter int unsigned STARVE_MAX = WB_STARVE_MAX
) (
    input  logic                clock,
    input  logic                reset_n,
    wb_write_arbiter_if.slave   bus
);

    localparam int unsigned AGE_W = $clog2(STARVE_MAX) + 1;

    logic              w_full;
    logic              w_head_valid;
    pend_entry_t       w_head;
    logic              w_haz_rs;
    logic              w_haz_rt;

    logic              w_wb_req;
    logic              w_push;
    logic              w_pop;
    logic              w_mark;
    grant_t            w_grant;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_age_inc;
    logic              w_stall_next;

    logic [AGE_W-1:0]  r_age;
    logic              r_stall;
    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    assign w_wb_req = bus.wb_RegWrite && (bus.wb_reg_dest != '0);
    assign w_push   = bus.md_valid && !w_full && (bus.md_reg_dest != '0);

    wb_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_push       (w_push),
        .i_push_dest  (bus.md_reg_dest),
        .i_push_data  (bus.md_data),
        .i_pop        (w_pop),
        .i_mark       (w_mark),
        .i_mark_dest  (bus.wb_reg_dest),
        .i_rs_addr    (bus.rs_addr),
        .i_rt_addr    (bus.rt_addr),
        .o_full       (w_full),
        .o_head_valid (w_head_valid),
        .o_head       (w_head),
        .o_hazard_rs  (w_haz_rs),
        .o_hazard_rt  (w_haz_rt)
    );

    // Grant decision: forced drain, then WB, then idle-slot drain.
    always_comb begin
        w_grant = GNT_NONE;
        w_pop   = 1'b0;
        w_mark  = 1'b0;
        if (r_stall) begin
            // Pipeline is frozen, so the held WB request is ignored.
            w_pop = w_head_valid;
            if (w_head_valid && !w_head.stale) w_grant = GNT_PEND;
        end else if (w_wb_req) begin
            w_grant = GNT_WB;
            w_mark  = 1'b1;
            w_pop   = w_head_valid && w_head.stale;
        end else if (w_head_valid) begin
            w_pop = 1'b1;
            if (!w_head.stale) w_grant = GNT_PEND;
        end
    end

    // Write-port source mux for the granted requester.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        unique case (w_grant)
            GNT_WB: begin
                w_we    = 1'b1;
                w_waddr = bus.wb_reg_dest;
                w_wdata = bus.wb_data;
            end
            GNT_PEND: begin
                w_we    = 1'b1;
                w_waddr = w_head.dest;
                w_wdata = w_head.data;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // Starvation detect: a live head left waiting one more cycle.
    always_comb begin
        w_age_inc    = w_head_valid && !w_head.stale && !w_pop;
        w_stall_next = w_age_inc
                    && ((r_age + AGE_W'(1)) == AGE_W'(STARVE_MAX - 1));
    end

    // Age counter and one-cycle stall pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_age   <= '0;
            r_stall <= 1'b0;
        end else begin
            if (!w_head_valid || w_pop) begin
                r_age <= '0;
            end else if (w_age_inc) begin
                r_age <= r_age + AGE_W'(1);
            end
            r_stall <= w_stall_next;
        end
    end

    // Registered register-file write port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_we;
            if (w_we) begin
                r_rf_waddr <= w_waddr;
                r_rf_wdata <= w_wdata;
            end
        end
    end

    assign bus.md_ready  = !w_full;
    assign bus.stall_req = r_stall;
    assign bus.rf_we     = r_rf_we;
    assign bus.rf_waddr  = r_rf_waddr;
    assign bus.rf_wdata  = r_rf_wdata;
    assign bus.hazard_rs = w_haz_rs;
    assign bus.hazard_rt = w_haz_rt;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter.
// Inputs change at posedge+1, outputs are checked at posedge+2.
module tb_wb_write_arbiter;

    logic clock;
    logic reset_n;

    int n_chk  = 0;
    int n_fail = 0;

    wb_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_write_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .DEPTH      (2),
        .STARVE_MAX (4)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] d,
                          input logic [31:0] v);
        bus.wb_RegWrite = en;
        bus.wb_reg_dest = d;
        bus.wb_data     = v;
    endtask

    task automatic set_md(input logic en, input logic [4:0] d,
                          input logic [31:0] v);
        bus.md_valid    = en;
        bus.md_reg_dest = d;
        bus.md_data     = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0]  q_dest [$];
        logic [31:0] q_data [$];
        int          q_cyc  [$];
        int          rdy_cyc;
        logic        drop;

        reset_n = 1'b0;
        set_wb(0, 0, 0);
        set_md(0, 0, 0);
        bus.rs_addr = 0;
        bus.rt_addr = 0;
        repeat (2) @(posedge clock);
        #2;
        check_eq("rst_we", bus.rf_we, 0);
        check_eq("rst_waddr", bus.rf_waddr, 0);
        check_eq("rst_wdata", bus.rf_wdata, 0);
        check_eq("rst_stall", bus.stall_req, 0);
        check_eq("rst_ready", bus.md_ready, 1);
        check_eq("rst_haz", {bus.hazard_rs, bus.hazard_rt}, 0);
        reset_n = 1'b1;

        // Idle WB: drain two cycles after the push cycle.
        cyc();
        set_md(1, 3, 32'h11);
        bus.rt_addr = 3;
        #1;
        check_eq("t1_haz_push", bus.hazard_rt, 0);
        cyc();
        set_md(0, 0, 0);
        #1;
        check_eq("t1_haz_pend", bus.hazard_rt, 1);
        check_eq("t1_we_early", bus.rf_we, 0);
        cyc();
        #1;
        check_eq("t1_we", bus.rf_we, 1);
        check_eq("t1_waddr", bus.rf_waddr, 3);
        check_eq("t1_wdata", bus.rf_wdata, 32'h11);
        check_eq("t1_haz_gone", bus.hazard_rt, 0);
        cyc();
        #1;
        check_eq("t1_we_once", bus.rf_we, 0);
        bus.rt_addr = 0;

        // Collision: WB busy on r7, mul/div waits on r4 until forced drain.
        cyc();
        set_wb(1, 7, 32'h77);
        set_md(1, 4, 32'h22);
        bus.rs_addr = 4;
        #1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            if (i == 1) set_md(0, 0, 0);
            #1;
            check_eq($sformatf("t2_nostall_%0d", i), bus.stall_req, 0);
            check_eq($sformatf("t2_wbaddr_%0d", i), bus.rf_waddr, 7);
            check_eq($sformatf("t2_haz_%0d", i), bus.hazard_rs, 1);
        end
        cyc();
        #1;
        check_eq("t2_stall", bus.stall_req, 1);
        cyc();
        #1;
        check_eq("t2_stall_off", bus.stall_req, 0);
        check_eq("t2_md_we", bus.rf_we, 1);
        check_eq("t2_md_addr", bus.rf_waddr, 4);
        check_eq("t2_md_data", bus.rf_wdata, 32'h22);
        cyc();
        #1;
        check_eq("t2_wb_addr", bus.rf_waddr, 7);
        check_eq("t2_wb_data", bus.rf_wdata, 32'h77);
        set_wb(0, 0, 0);
        cyc();
        cyc();
        #1;
        check_eq("t2_idle", bus.rf_we, 0);

        // Stale: newer WB value for r5 supersedes the pending entry.
        set_wb(1, 9, 32'h99);
        set_md(1, 5, 32'hAA);
        bus.rs_addr = 5;
        #1;
        cyc();
        set_md(0, 0, 0);
        set_wb(1, 5, 32'hBB);
        #1;
        check_eq("t3_haz_live", bus.hazard_rs, 1);
        cyc();
        set_wb(0, 0, 0);
        #1;
        check_eq("t3_haz_stale", bus.hazard_rs, 0);
        check_eq("t3_wb_addr", bus.rf_waddr, 5);
        check_eq("t3_wb_data", bus.rf_wdata, 32'hBB);
        cyc();
        #1;
        check_eq("t3_silent_pop", bus.rf_we, 0);
        cyc();
        #1;
        check_eq("t3_silent_pop2", bus.rf_we, 0);
        check_eq("t3_ready", bus.md_ready, 1);
        bus.rs_addr = 0;

        // Full: two entries with WB busy, third held until space frees.
        cyc();
        set_wb(1, 8, 32'h88);
        set_md(1, 10, 32'hA1);
        #1;
        check_eq("t4_ready0", bus.md_ready, 1);
        cyc();
        set_md(1, 11, 32'hA2);
        #1;
        check_eq("t4_ready1", bus.md_ready, 1);
        cyc();
        set_md(1, 12, 32'hA3);
        bus.rt_addr = 11;
        #1;
        check_eq("t4_full", bus.md_ready, 0);
        check_eq("t4_haz11", bus.hazard_rt, 1);
        rdy_cyc = -1;
        drop = 1'b0;
        for (int k = 3; k <= 16; k++) begin
            cyc();
            if (drop) set_md(0, 0, 0);
            drop = 1'b0;
            #1;
            if (bus.md_valid && bus.md_ready) begin
                drop = 1'b1;
                rdy_cyc = k;
            end
            if (bus.rf_we && bus.rf_waddr != 8) begin
                q_dest.push_back(bus.rf_waddr);
                q_data.push_back(bus.rf_wdata);
                q_cyc.push_back(k);
            end
        end
        check_eq("t4_ready_cyc", rdy_cyc, 5);
        check_eq("t4_count", q_dest.size(), 3);
        if (q_dest.size() == 3) begin
            check_eq("t4_d0", q_dest[0], 10);
            check_eq("t4_v0", q_data[0], 32'hA1);
            check_eq("t4_c0", q_cyc[0], 5);
            check_eq("t4_d1", q_dest[1], 11);
            check_eq("t4_v1", q_data[1], 32'hA2);
            check_eq("t4_c1", q_cyc[1], 9);
            check_eq("t4_d2", q_dest[2], 12);
            check_eq("t4_v2", q_data[2], 32'hA3);
            check_eq("t4_c2", q_cyc[2], 13);
        end
        set_wb(0, 0, 0);
        set_md(0, 0, 0);
        bus.rt_addr = 0;
        cyc();
        cyc();

        // Zero register: both writes dropped.
        set_md(1, 0, 32'h55);
        set_wb(1, 0, 32'h66);
        #1;
        cyc();
        set_md(0, 0, 0);
        set_wb(0, 0, 0);
        #1;
        check_eq("t5_we", bus.rf_we, 0);
        check_eq("t5_ready", bus.md_ready, 1);
        cyc();
        #1;
        check_eq("t5_we2", bus.rf_we, 0);
        check_eq("t5_stall", bus.stall_req, 0);

        // Reset with two pending entries.
        cyc();
        set_wb(1, 14, 32'hE0);
        set_md(1, 20, 32'hC1);
        #1;
        cyc();
        set_md(1, 21, 32'hC2);
        #1;
        cyc();
        set_md(0, 0, 0);
        bus.rs_addr = 20;
        bus.rt_addr = 21;
        #1;
        check_eq("t6_full", bus.md_ready, 0);
        check_eq("t6_haz_rs", bus.hazard_rs, 1);
        check_eq("t6_wb_we", bus.rf_we, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t6_rst_we", bus.rf_we, 0);
        check_eq("t6_rst_waddr", bus.rf_waddr, 0);
        check_eq("t6_rst_wdata", bus.rf_wdata, 0);
        check_eq("t6_rst_stall", bus.stall_req, 0);
        check_eq("t6_rst_ready", bus.md_ready, 1);
        check_eq("t6_rst_haz", {bus.hazard_rs, bus.hazard_rt}, 0);
        set_wb(0, 0, 0);
        cyc();
        cyc();
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            #1;
            check_eq($sformatf("t6_nowrite_%0d", k), bus.rf_we, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
